cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

CPU control unit: owns the privileged control registers, answers the ID-stage decoder's control-register reads and execution-mode query, and consumes the `ctrl_op`/`exp_code` results the decoder produced once they reach MEM. Arbitrates pipeline stall/flush, takes exceptions and external interrupts precisely at MEM, executes WRCR/EXRT, and supplies the redirect PC to IF. It sits beside the five pipeline stages and is the only writer of `exe_mode`.

## Interface
- no parameters; encodings fixed: exe_mode KERNEL=0/USER=1; ctrl_op NOP=0, WRCR=1, EXRT=2; exp_code NO_EXP=0, EXT_INT=1, UNDEF_INSN=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6
- clk  in  1  system clock
- reset_  in  1  asynchronous, active-low reset
- creg_rd_addr  in  5  control register read address (from decoder)
- creg_rd_data  out  32  combinational read data
- exe_mode  out  1  current execution mode (registered)
- irq  in  8  level-sensitive interrupt requests
- int_detect  out  1  unmasked interrupt pending and enabled
- if_busy, mem_busy, ld_hazard  in  1 each  stall sources
- mem_en  in  1  MEM-stage valid
- mem_pc  in  30  MEM-stage word PC
- mem_br_flag  in  1  MEM instruction is a branch
- mem_ctrl_op  in  2  MEM-stage control op
- mem_dst_addr  in  5  creg write address for WRCR
- mem_exp_code  in  3  MEM-stage exception code
- mem_out  in  32  WRCR write data
- if_stall, id_stall, ex_stall, mem_stall  out  1 each
- if_flush, id_flush, ex_flush, mem_flush  out  1 each
- new_pc  out  30  redirect target, valid while flushing

## Operation
- Registers (addr: field): 0 STATUS {int_en[1], exe_mode[0]}; 1 PRE_STATUS {pre_int_en[1], pre_exe_mode[0]}; 2 EPC [31:2]=epc, [1:0]=0; 3 EXP_VECTOR [31:2]; 4 CAUSE {dly_flag[3], exp_code[2:0]}; 5 INT_MASK [7:0] (1 = masked); 6 IRQ [7:0] raw irq (read-only). Addresses 7–31 read 0, writes ignored. Unused bits read 0.
- Reset: exe_mode=KERNEL, int_en=0, pre_*=0, epc=0, exp_vector=0, cause=0, int_mask=8'hFF; all flush outputs 0, new_pc=0.
- int_detect = int_en & |(irq & ~int_mask).
- stall = if_busy | mem_busy. if_stall = stall | ld_hazard; id/ex/mem_stall = stall.
- Event selection, evaluated only when mem_en=1 and stall=0, priority high→low:
  - exception: mem_exp_code≠0.
  - interrupt: int_detect=1, treated as EXT_INT.
  - EXRT: mem_ctrl_op=EXRT.
  - WRCR: mem_ctrl_op=WRCR.
- Exception/interrupt: all four flushes=1; new_pc=exp_vector. At clock edge: epc = mem_br_flag ? mem_pc−1 : mem_pc (30-bit wrap); cause = {mem_br_flag, code}; pre_exe_mode←exe_mode; pre_int_en←int_en; exe_mode←KERNEL; int_en←0.
- EXRT: all flushes=1; new_pc=epc. At edge: exe_mode←pre_exe_mode; int_en←pre_int_en.
- WRCR: write mem_out into register mem_dst_addr. No flush. A write to STATUS takes effect the next cycle.
- id_flush additionally =1 when ld_hazard=1 and stall=0, which inserts a bubble into ID/EX.
- No event: flushes 0 except the ld_hazard case; new_pc=0.

## Timing
- creg_rd_data and all stall/flush/new_pc outputs are combinational, same cycle.
- Register updates are visible the cycle after the event edge.
- No creg read bypass: a RDCR in ID in the same cycle as a WRCR in MEM to the same address returns the old value.
- mem_busy=1 holds all state. An exception held in MEM is taken on the first cycle stall falls.
- Reset asserted mid-operation: every register returns to reset values immediately, asynchronously.

## Test plan
- Reset: read all addresses → STATUS=0, INT_MASK=32'h000000FF, others 0; all flushes 0.
- WRCR: mem_en=1, ctrl_op=WRCR, dst=3, mem_out=32'h0000_1000 → next cycle addr 3 reads 32'h0000_1000, no flush. Same-cycle RDCR of addr 3 returns the old 0.
- TRAP: exp_vector=0x400 (word), exe_mode=USER, int_en=1, mem_pc=0x20, br_flag=0, exp_code=5 → same cycle all flushes=1, new_pc=0x400. Next cycle: EPC reads 0x80, CAUSE=5, exe_mode=KERNEL, PRE_STATUS=2'b11, STATUS=0.
- Branch-slot exception: mem_pc=0x20, br_flag=1, exp_code=2 → EPC reads 0x7C, CAUSE=4'b1010. Then EXRT → new_pc=0x1F, flush, exe_mode/int_en restored.
- Interrupt: int_en=1, mask=8'hFE, irq=8'h01, mem_en=1 → int_detect=1, flush, CAUSE=1. irq=8'h02 → no int_detect.
- Stall priority: mem_busy=1 with exp_code=5 → all stalls 1, no flush, state unchanged. mem_busy drops → exception taken that cycle. ld_hazard alone → if_stall=1, id_flush=1, others 0.

Source files
------------

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: privileged control registers, stall/flush arbitration, precise
// exception/interrupt entry at MEM, WRCR/EXRT execution and IF redirect PC.
// Ports:
//   clk, reset_                 clock, async active-low reset
//   creg_rd_addr/creg_rd_data   decoder control-register read (comb)
//   exe_mode                    current execution mode (registered)
//   irq, int_detect             interrupt requests / enabled+unmasked pending
//   if_busy, mem_busy, ld_hazard  stall sources
//   mem_*                       MEM-stage instruction info and WRCR data
//   *_stall, *_flush, new_pc    pipeline control (comb)
module cpu_ctrl (
  input  logic        clk,
  input  logic        reset_,
  input  logic [4:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  output logic        exe_mode,
  input  logic [7:0]  irq,
  output logic        int_detect,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        mem_en,
  input  logic [29:0] mem_pc,
  input  logic        mem_br_flag,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_dst_addr,
  input  logic [2:0]  mem_exp_code,
  input  logic [31:0] mem_out,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc
);

  localparam int unsigned PC_W = 30;

  localparam logic       MODE_KERNEL = 1'b0;
  localparam logic [1:0] OP_WRCR     = 2'd1;
  localparam logic [1:0] OP_EXRT     = 2'd2;
  localparam logic [2:0] EXP_NONE    = 3'd0;
  localparam logic [2:0] EXP_EXT_INT = 3'd1;

  localparam logic [4:0] CR_STATUS     = 5'd0;
  localparam logic [4:0] CR_PRE_STATUS = 5'd1;
  localparam logic [4:0] CR_EPC        = 5'd2;
  localparam logic [4:0] CR_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CR_CAUSE      = 5'd4;
  localparam logic [4:0] CR_INT_MASK   = 5'd5;
  localparam logic [4:0] CR_IRQ        = 5'd6;

  logic            int_en;
  logic            pre_exe_mode;
  logic            pre_int_en;
  logic [PC_W-1:0] epc;
  logic [PC_W-1:0] exp_vector;
  logic            dly_flag;
  logic [2:0]      exp_code;
  logic [7:0]      int_mask;

  logic            stall;
  logic            mem_go;
  logic            take_exc;
  logic            take_int;
  logic            take_trap_c;
  logic            do_exrt;
  logic            do_wrcr;
  logic            flush_all;
  logic [2:0]      trap_code;

  // Control register read port; no bypass from a same-cycle WRCR
  always_comb begin
    creg_rd_data = 32'h0;
    case (creg_rd_addr)
      CR_STATUS:     creg_rd_data = {30'h0, int_en, exe_mode};
      CR_PRE_STATUS: creg_rd_data = {30'h0, pre_int_en, pre_exe_mode};
      CR_EPC:        creg_rd_data = {epc, 2'b00};
      CR_EXP_VECTOR: creg_rd_data = {exp_vector, 2'b00};
      CR_CAUSE:      creg_rd_data = {28'h0, dly_flag, exp_code};
      CR_INT_MASK:   creg_rd_data = {24'h0, int_mask};
      CR_IRQ:        creg_rd_data = {24'h0, irq};
      default:       creg_rd_data = 32'h0;
    endcase
  end

  assign int_detect = int_en & (|(irq & ~int_mask));

  assign stall     = if_busy | mem_busy;
  assign if_stall  = stall | ld_hazard;
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;

  // Event priority at MEM: exception > interrupt > EXRT > WRCR
  assign mem_go      = mem_en & ~stall;
  assign take_exc    = mem_go & (mem_exp_code != EXP_NONE);
  assign take_int    = mem_go & ~take_exc & int_detect;
  assign take_trap_c = take_exc | take_int;
  assign do_exrt     = mem_go & ~take_trap_c & (mem_ctrl_op == OP_EXRT);
  assign do_wrcr     = mem_go & ~take_trap_c & (mem_ctrl_op == OP_WRCR);
  assign flush_all   = take_trap_c | do_exrt;
  assign trap_code   = take_exc ? mem_exp_code : EXP_EXT_INT;

  // ld_hazard bubbles ID/EX even without another event
  assign if_flush  = flush_all;
  assign id_flush  = flush_all | (ld_hazard & ~stall);
  assign ex_flush  = flush_all;
  assign mem_flush = flush_all;

  always_comb begin
    new_pc = '0;
    if (take_trap_c)  new_pc = exp_vector;
    else if (do_exrt) new_pc = epc;
  end

  // Control register state
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      exe_mode     <= MODE_KERNEL;
      int_en       <= 1'b0;
      pre_exe_mode <= 1'b0;
      pre_int_en   <= 1'b0;
      epc          <= '0;
      exp_vector   <= '0;
      dly_flag     <= 1'b0;
      exp_code     <= 3'd0;
      int_mask     <= 8'hFF;
    end else if (take_trap_c) begin
      // Branch-slot faults resume at the branch itself
      epc          <= mem_br_flag ? (mem_pc - PC_W'(1)) : mem_pc;
      dly_flag     <= mem_br_flag;
      exp_code     <= trap_code;
      pre_exe_mode <= exe_mode;
      pre_int_en   <= int_en;
      exe_mode     <= MODE_KERNEL;
      int_en       <= 1'b0;
    end else if (do_exrt) begin
      exe_mode <= pre_exe_mode;
      int_en   <= pre_int_en;
    end else if (do_wrcr) begin
      case (mem_dst_addr)
        CR_STATUS: begin
          int_en   <= mem_out[1];
          exe_mode <= mem_out[0];
        end
        CR_PRE_STATUS: begin
          pre_int_en   <= mem_out[1];
          pre_exe_mode <= mem_out[0];
        end
        CR_EPC:        epc        <= mem_out[31:2];
        CR_EXP_VECTOR: exp_vector <= mem_out[31:2];
        CR_CAUSE: begin
          dly_flag <= mem_out[3];
          exp_code <= mem_out[2:0];
        end
        CR_INT_MASK:   int_mask   <= mem_out[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic [7:0]  irq;
  logic        int_detect;
  logic        if_busy, mem_busy, ld_hazard;
  logic        mem_en;
  logic [29:0] mem_pc;
  logic        mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk          (clk),
    .reset_       (reset_),
    .creg_rd_addr (creg_rd_addr),
    .creg_rd_data (creg_rd_data),
    .exe_mode     (exe_mode),
    .irq          (irq),
    .int_detect   (int_detect),
    .if_busy      (if_busy),
    .mem_busy     (mem_busy),
    .ld_hazard    (ld_hazard),
    .mem_en       (mem_en),
    .mem_pc       (mem_pc),
    .mem_br_flag  (mem_br_flag),
    .mem_ctrl_op  (mem_ctrl_op),
    .mem_dst_addr (mem_dst_addr),
    .mem_exp_code (mem_exp_code),
    .mem_out      (mem_out),
    .if_stall     (if_stall),
    .id_stall     (id_stall),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .ex_flush     (ex_flush),
    .mem_flush    (mem_flush),
    .new_pc       (new_pc)
  );

  wire [3:0] flushes = {if_flush, id_flush, ex_flush, mem_flush};
  wire [3:0] stalls  = {if_stall, id_stall, ex_stall, mem_stall};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    creg_rd_addr = addr;
    #1;
    check(tag, creg_rd_data, exp);
  endtask

  // Advance one clock, landing just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_mem();
    mem_en = 1'b0; mem_ctrl_op = 2'd0; mem_exp_code = 3'd0;
    mem_br_flag = 1'b0; mem_dst_addr = 5'd0; mem_out = 32'h0;
  endtask

  task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = addr; mem_out = data;
    tick();
    idle_mem();
  endtask

  logic [31:0] rst_exp [7];

  initial begin
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0};
    reset_ = 1'b0;
    creg_rd_addr = 5'd0; irq = 8'h0;
    if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
    mem_pc = 30'h0;
    idle_mem();

    // Reset values
    #2;
    for (int a = 0; a < 7; a++) rd(5'(a), $sformatf("rst_cr%0d", a), rst_exp[a]);
    check("rst_flush", 32'(flushes), 32'h0);
    check("rst_new_pc", 32'(new_pc), 32'h0);
    check("rst_mode", 32'(exe_mode), 32'h0);
    #2 reset_ = 1'b1;
    tick();

    // WRCR to EXP_VECTOR; same-cycle read sees old value
    mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd3; mem_out = 32'h0000_1000;
    rd(5'd3, "wrcr_same_cycle", 32'h0);
    check("wrcr_noflush", 32'(flushes), 32'h0);
    tick();
    idle_mem();
    rd(5'd3, "wrcr_next", 32'h0000_1000);

    // Enter USER with interrupts enabled
    wrcr(5'd0, 32'h3);
    rd(5'd0, "status_user", 32'h3);
    check("mode_user", 32'(exe_mode), 32'h1);

    // TRAP
    mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h20;
    #1;
    check("trap_flush", 32'(flushes), 32'hF);
    check("trap_new_pc", 32'(new_pc), 32'h400);
    tick();
    idle_mem();
    rd(5'd2, "trap_epc", 32'h80);
    rd(5'd4, "trap_cause", 32'h5);
    rd(5'd1, "trap_pre_status", 32'h3);
    rd(5'd0, "trap_status", 32'h0);
    check("trap_mode", 32'(exe_mode), 32'h0);

    // Branch-slot exception, then EXRT
    wrcr(5'd0, 32'h3);
    mem_en = 1'b1; mem_exp_code = 3'd2; mem_br_flag = 1'b1; mem_pc = 30'h20;
    tick();
    idle_mem();
    rd(5'd2, "br_epc", 32'h7C);
    rd(5'd4, "br_cause", 32'hA);
    mem_en = 1'b1; mem_ctrl_op = 2'd2;
    #1;
    check("exrt_new_pc", 32'(new_pc), 32'h1F);
    check("exrt_flush", 32'(flushes), 32'hF);
    tick();
    idle_mem();
    rd(5'd0, "exrt_status", 32'h3);
    check("exrt_mode", 32'(exe_mode), 32'h1);

    // Interrupt
    wrcr(5'd5, 32'hFE);
    irq = 8'h02;
    #1;
    check("irq_masked", 32'(int_detect), 32'h0);
    irq = 8'h01;
    #1;
    check("irq_detect", 32'(int_detect), 32'h1);
    mem_en = 1'b1; mem_pc = 30'h20;
    #1;
    check("int_flush", 32'(flushes), 32'hF);
    check("int_new_pc", 32'(new_pc), 32'h400);
    tick();
    idle_mem();
    rd(5'd4, "int_cause", 32'h1);
    rd(5'd6, "int_irq_reg", 32'h1);
    rd(5'd0, "int_status", 32'h0);
    check("int_detect_off", 32'(int_detect), 32'h0);
    irq = 8'h0;

    // Stall holds a pending exception
    mem_busy = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h10;
    #1;
    check("stall_all", 32'(stalls), 32'hF);
    check("stall_noflush", 32'(flushes), 32'h0);
    check("stall_new_pc", 32'(new_pc), 32'h0);
    tick();
    rd(5'd2, "stall_epc_held", 32'h80);
    mem_busy = 1'b0;
    #1;
    check("unstall_flush", 32'(flushes), 32'hF);
    tick();
    idle_mem();
    rd(5'd2, "unstall_epc", 32'h40);
    rd(5'd4, "unstall_cause", 32'h5);

    // ld_hazard alone
    ld_hazard = 1'b1;
    #1;
    check("ldh_stall", 32'(stalls), 32'h8);
    check("ldh_flush", 32'(flushes), 32'h4);
    ld_hazard = 1'b0;

    // Unmapped address ignores writes
    wrcr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, "unmapped", 32'h0);
    rd(5'd3, "vec_kept", 32'h1000);

    // Asynchronous reset mid-operation
    wrcr(5'd0, 32'h1);
    reset_ = 1'b0;
    rd(5'd5, "arst_mask", 32'hFF);
    rd(5'd2, "arst_epc", 32'h0);
    check("arst_mode", 32'(exe_mode), 32'h0);
    reset_ = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
